// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue instruction fetch queue.
package fetch_pkg;

   localparam int          DEFAULT_DEPTH = 8;
   localparam logic [31:0] NOP_INST      = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Instruction-memory, redirect and decode-side signals of the fetch queue.
interface inst_fetch_queue_if;

   logic [31:0] imem_addr0;
   logic [31:0] imem_addr1;
   logic [31:0] imem_inst0;
   logic [31:0] imem_inst1;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [1:0]  dec_valid;
   logic [31:0] dec_inst0;
   logic [31:0] dec_pc0;
   logic [31:0] dec_inst1;
   logic [31:0] dec_pc1;
   logic [1:0]  dec_take;

   modport master (
      output imem_addr0, imem_addr1, dec_valid, dec_inst0, dec_pc0, dec_inst1, dec_pc1,
      input  imem_inst0, imem_inst1, redirect_valid, redirect_pc, dec_take
   );

   modport slave (
      input  imem_addr0, imem_addr1, dec_valid, dec_inst0, dec_pc0, dec_inst1, dec_pc1,
      output imem_inst0, imem_inst1, redirect_valid, redirect_pc, dec_take
   );

endinterface

// File: rtl/fetch_fifo.sv
// Two-write / two-read circular buffer of fetch entries with occupancy count and flush.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter  int DEPTH = DEFAULT_DEPTH,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t wr_data0,
   input  fetch_entry_t wr_data1,
   input  logic [1:0]   pop_cnt,
   output fetch_entry_t rd_data0,
   output fetch_entry_t rd_data1,
   output logic [CW-1:0] count
);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr_p1;
   logic [AW-1:0] wr_ptr_p1;

   assign rd_ptr_p1 = rd_ptr + AW'(1);
   assign wr_ptr_p1 = wr_ptr + AW'(1);

   // Pushes always come in pairs; the caller guarantees room and clamps pop_cnt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(2);
         rd_ptr <= rd_ptr + AW'(pop_cnt);
         count  <= count + (push ? CW'(2) : CW'(0)) - CW'(pop_cnt);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr]    <= wr_data0;
         mem[wr_ptr_p1] <= wr_data1;
      end
   end

   assign rd_data0 = mem[rd_ptr];
   assign rd_data1 = mem[rd_ptr_p1];

endmodule

// File: rtl/inst_fetch_queue.sv
// Dual-issue fetch stage: owns the PC, pushes fetched pairs into fetch_fifo, handles redirects.
// Define INST_FETCH_PERF_EN to add the perf_stall_cycles / perf_issued counters.
module inst_fetch_queue
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = DEFAULT_DEPTH,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst_n,
`ifdef INST_FETCH_PERF_EN
   output logic [31:0]        perf_stall_cycles,
   output logic [31:0]        perf_issued,
`endif
   inst_fetch_queue_if.master fetch_bus
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]   pc;
   logic [CW-1:0] count;
   logic          room;
   logic          push;
   logic [1:0]    avail;
   logic [1:0]    accepted;
   fetch_entry_t  wr_data0;
   fetch_entry_t  wr_data1;
   fetch_entry_t  rd_data0;
   fetch_entry_t  rd_data1;

   assign fetch_bus.imem_addr0 = pc;
   assign fetch_bus.imem_addr1 = pc + 32'd4;

   // Room is judged on the registered count so a full queue never relies on a same-cycle pop.
   assign room  = (count <= CW'(DEPTH - 2));
   assign push  = room && !fetch_bus.redirect_valid;
   assign avail = (count >= CW'(2)) ? 2'd2 : count[1:0];

   always_comb begin
      accepted = fetch_bus.dec_take;
      if (fetch_bus.dec_take > avail)
         accepted = avail;
      if (fetch_bus.redirect_valid)
         accepted = 2'd0;
   end

   assign wr_data0 = '{pc: pc,          inst: fetch_bus.imem_inst0};
   assign wr_data1 = '{pc: pc + 32'd4,  inst: fetch_bus.imem_inst1};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pc <= RESET_PC;
      else if (fetch_bus.redirect_valid)
         pc <= align_pc(fetch_bus.redirect_pc);
      else if (push)
         pc <= pc + 32'd8;
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (fetch_bus.redirect_valid),
      .push     (push),
      .wr_data0 (wr_data0),
      .wr_data1 (wr_data1),
      .pop_cnt  (accepted),
      .rd_data0 (rd_data0),
      .rd_data1 (rd_data1),
      .count    (count)
   );

   // Empty decode slots show a NOP at PC 0 rather than stale buffer contents.
   always_comb begin
      fetch_bus.dec_valid = {count >= CW'(2), count >= CW'(1)};
      fetch_bus.dec_inst0 = NOP_INST;
      fetch_bus.dec_pc0   = 32'd0;
      fetch_bus.dec_inst1 = NOP_INST;
      fetch_bus.dec_pc1   = 32'd0;
      if (count >= CW'(1)) begin
         fetch_bus.dec_inst0 = rd_data0.inst;
         fetch_bus.dec_pc0   = rd_data0.pc;
      end
      if (count >= CW'(2)) begin
         fetch_bus.dec_inst1 = rd_data1.inst;
         fetch_bus.dec_pc1   = rd_data1.pc;
      end
   end

`ifdef INST_FETCH_PERF_EN
   logic [32:0] issued_sum;

   assign issued_sum = {1'b0, perf_issued} + 33'(accepted);

   // Both counters saturate; redirect cycles are neither stalls nor issues.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cycles <= '0;
         perf_issued       <= '0;
      end else if (!fetch_bus.redirect_valid) begin
         if (!room && (perf_stall_cycles != 32'hFFFF_FFFF))
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         perf_issued <= issued_sum[32] ? 32'hFFFF_FFFF : issued_sum[31:0];
      end
   end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue (DEPTH=8, RESET_PC=0).
module tb_inst_fetch_queue;
   import fetch_pkg::*;

   logic clk;
   logic rst_n;
   int   compared;
   int   mismatched;

   inst_fetch_queue_if bus ();

`ifdef INST_FETCH_PERF_EN
   logic [31:0] perf_stall_cycles;
   logic [31:0] perf_issued;
`endif

   inst_fetch_queue #(.DEPTH(8), .RESET_PC(32'h0000_0000)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
`ifdef INST_FETCH_PERF_EN
      .perf_stall_cycles (perf_stall_cycles),
      .perf_issued       (perf_issued),
`endif
      .fetch_bus         (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: the two ADDIs at 0/4, an address-unique pattern elsewhere.
   function automatic logic [31:0] imem_model(input logic [31:0] addr);
      case (addr)
         32'h0000_0000: return 32'h0050_0093;
         32'h0000_0004: return 32'h0030_0113;
         default:       return {addr[23:2], 10'h013};
      endcase
   endfunction

   assign bus.imem_inst0 = imem_model(bus.imem_addr0);
   assign bus.imem_inst1 = imem_model(bus.imem_addr1);

   always @(negedge clk) begin
      if (rst_n && (int'(bus.dec_take) > $countones(bus.dec_valid)))
         $error("[TB] protocol error: dec_take=%0d with dec_valid=%b", bus.dec_take, bus.dec_valid);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.dec_take       = 2'd0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'd0;
      rst_n = 1'b0;
      #12;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.dec_take       = 2'd0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'd0;
      rst_n = 1'b0;
      #12;
      compared++; if (bus.dec_valid !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_valid: got %b expected 00", bus.dec_valid); end
      compared++; if (bus.dec_inst0 !== NOP_INST) begin mismatched++; $display("[TB] FAIL reset_inst0: got %h expected %h", bus.dec_inst0, NOP_INST); end
      compared++; if (bus.dec_pc1 !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_pc1: got %h expected 0", bus.dec_pc1); end
      compared++; if (bus.imem_addr0 !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_addr0: got %h expected 0", bus.imem_addr0); end
      compared++; if (bus.imem_addr1 !== 32'd4) begin mismatched++; $display("[TB] FAIL reset_addr1: got %h expected 4", bus.imem_addr1); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_first_fetch();
      step();
      compared++; if (bus.dec_valid !== 2'b11) begin mismatched++; $display("[TB] FAIL first_valid: got %b expected 11", bus.dec_valid); end
      compared++; if (bus.dec_inst0 !== 32'h0050_0093) begin mismatched++; $display("[TB] FAIL first_inst0: got %h expected 00500093", bus.dec_inst0); end
      compared++; if (bus.dec_pc0 !== 32'h0) begin mismatched++; $display("[TB] FAIL first_pc0: got %h expected 0", bus.dec_pc0); end
      compared++; if (bus.dec_inst1 !== 32'h0030_0113) begin mismatched++; $display("[TB] FAIL first_inst1: got %h expected 00300113", bus.dec_inst1); end
      compared++; if (bus.dec_pc1 !== 32'h4) begin mismatched++; $display("[TB] FAIL first_pc1: got %h expected 4", bus.dec_pc1); end
      compared++; if (bus.imem_addr0 !== 32'h8) begin mismatched++; $display("[TB] FAIL first_addr0: got %h expected 8", bus.imem_addr0); end
   endtask

   task automatic test_full_stall();
      logic [31:0] exp_pc;
      do_reset();
      repeat (5) step();
      compared++; if (bus.imem_addr0 !== 32'h20) begin mismatched++; $display("[TB] FAIL stall_pc_c5: got %h expected 20", bus.imem_addr0); end
      repeat (5) step();
      compared++; if (bus.imem_addr0 !== 32'h20) begin mismatched++; $display("[TB] FAIL stall_pc_c10: got %h expected 20", bus.imem_addr0); end
      compared++; if (bus.dec_valid !== 2'b11) begin mismatched++; $display("[TB] FAIL stall_valid: got %b expected 11", bus.dec_valid); end
      exp_pc = 32'd0;
      for (int i = 0; i < 8; i++) begin
         compared++; if (bus.dec_pc0 !== exp_pc) begin mismatched++; $display("[TB] FAIL drain_pc0[%0d]: got %h expected %h", i, bus.dec_pc0, exp_pc); end
         compared++; if (bus.dec_pc1 !== exp_pc + 32'd4) begin mismatched++; $display("[TB] FAIL drain_pc1[%0d]: got %h expected %h", i, bus.dec_pc1, exp_pc + 32'd4); end
         compared++; if (bus.dec_inst1 !== imem_model(exp_pc + 32'd4)) begin mismatched++; $display("[TB] FAIL drain_inst1[%0d]: got %h expected %h", i, bus.dec_inst1, imem_model(exp_pc + 32'd4)); end
         bus.dec_take = 2'd2;
         step();
         exp_pc = exp_pc + 32'd8;
      end
      bus.dec_take = 2'd0;
   endtask

   task automatic test_single_take();
      logic [31:0] exp_pc;
      do_reset();
      step();
      exp_pc = 32'd0;
      bus.dec_take = 2'd1;
      for (int i = 0; i < 20; i++) begin
         compared++; if (bus.dec_valid[0] !== 1'b1) begin mismatched++; $display("[TB] FAIL single_valid[%0d]: got %b expected 1", i, bus.dec_valid[0]); end
         compared++; if (bus.dec_pc0 !== exp_pc) begin mismatched++; $display("[TB] FAIL single_pc0[%0d]: got %h expected %h", i, bus.dec_pc0, exp_pc); end
         compared++; if (bus.dec_inst0 !== imem_model(exp_pc)) begin mismatched++; $display("[TB] FAIL single_inst0[%0d]: got %h expected %h", i, bus.dec_inst0, imem_model(exp_pc)); end
         step();
         exp_pc = exp_pc + 32'd4;
      end
      bus.dec_take = 2'd0;
   endtask

   task automatic test_redirect();
      do_reset();
      repeat (3) step();
      compared++; if (bus.imem_addr0 !== 32'h18) begin mismatched++; $display("[TB] FAIL redir_pre_pc: got %h expected 18", bus.imem_addr0); end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h0000_0042;
      step();
      bus.redirect_valid = 1'b0;
      compared++; if (bus.dec_valid !== 2'b00) begin mismatched++; $display("[TB] FAIL redir_valid_n1: got %b expected 00", bus.dec_valid); end
      compared++; if (bus.dec_inst0 !== NOP_INST) begin mismatched++; $display("[TB] FAIL redir_inst0_n1: got %h expected %h", bus.dec_inst0, NOP_INST); end
      compared++; if (bus.imem_addr0 !== 32'h40) begin mismatched++; $display("[TB] FAIL redir_addr0: got %h expected 40", bus.imem_addr0); end
      step();
      compared++; if (bus.dec_valid !== 2'b11) begin mismatched++; $display("[TB] FAIL redir_valid_n2: got %b expected 11", bus.dec_valid); end
      compared++; if (bus.dec_pc0 !== 32'h40) begin mismatched++; $display("[TB] FAIL redir_pc0: got %h expected 40", bus.dec_pc0); end
      compared++; if (bus.dec_pc1 !== 32'h44) begin mismatched++; $display("[TB] FAIL redir_pc1: got %h expected 44", bus.dec_pc1); end
      compared++; if (bus.dec_inst0 !== imem_model(32'h40)) begin mismatched++; $display("[TB] FAIL redir_inst0: got %h expected %h", bus.dec_inst0, imem_model(32'h40)); end
   endtask

   task automatic test_async_reset();
      do_reset();
      repeat (3) step();
      #2;
      rst_n = 1'b0;
      #1;
      compared++; if (bus.dec_valid !== 2'b00) begin mismatched++; $display("[TB] FAIL areset_valid: got %b expected 00", bus.dec_valid); end
      compared++; if (bus.dec_inst1 !== NOP_INST) begin mismatched++; $display("[TB] FAIL areset_inst1: got %h expected %h", bus.dec_inst1, NOP_INST); end
      compared++; if (bus.imem_addr0 !== 32'd0) begin mismatched++; $display("[TB] FAIL areset_addr0: got %h expected 0", bus.imem_addr0); end
      @(negedge clk);
      rst_n = 1'b1;
      test_first_fetch();
   endtask

`ifdef INST_FETCH_PERF_EN
   task automatic test_perf();
      do_reset();
      compared++; if (perf_issued !== 32'd0) begin mismatched++; $display("[TB] FAIL perf_reset_issued: got %0d expected 0", perf_issued); end
      repeat (8) step();
      bus.dec_take = 2'd2;
      repeat (3) step();
      bus.dec_take = 2'd1;
      step();
      bus.dec_take = 2'd0;
      compared++; if (perf_stall_cycles !== 32'd5) begin mismatched++; $display("[TB] FAIL perf_stall: got %0d expected 5", perf_stall_cycles); end
      compared++; if (perf_issued !== 32'd7) begin mismatched++; $display("[TB] FAIL perf_issued: got %0d expected 7", perf_issued); end
   endtask
`endif

   initial begin
      compared   = 0;
      mismatched = 0;
      test_reset();
      test_first_fetch();
      test_full_stall();
      test_single_take();
      test_redirect();
      test_async_reset();
`ifdef INST_FETCH_PERF_EN
      test_perf();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
